// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32I-subset core on a shared req/ready memory bus
//
// Purpose: sequences FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH} over a single
//   memory port; HALT is absorbing until reset. Holds PC, IR, register file and ALU.
// Optional feature macro: MULTICYCLE_CORE_BRANCH_FULL_EN (adds BLT/BGE/BLTU/BGEU).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mem_req    bus request, held with addr/we/wdata until mem_ready
//   mem_we     1 = store word, 0 = read
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  read data, valid while mem_ready=1
//   mem_ready  transfer completes this cycle (ignored when mem_req=0)
//   retire     one-cycle pulse per committed instruction
//   halt       sticky stop indication
module multicycle_core #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               NREGS    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            retire,
   output logic            halt
);

   localparam int SHW = $clog2(XLEN);
   localparam int RW  = $clog2(NREGS);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state, state_nx;
   logic              run;      // low for the first cycle after reset so mem_req rises one cycle late
   logic [XLEN-1:0]   pc, rs1_q, rs2_q, res_q, npc_q;
   logic [31:0]       ir;
   logic [XLEN-1:0]   rf [NREGS];

   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [RW-1:0]     rs1_idx, rs2_idx, rd_idx;
   logic [31:0]       imm32;
   logic [XLEN-1:0]   imm;
   logic              legal, uses_rd, uses_rs1, uses_rs2, dec_ok;

   assign opcode  = ir[6:0];
   assign f3      = ir[14:12];
   assign f7      = ir[31:25];
   assign rs1_idx = ir[15 +: RW];
   assign rs2_idx = ir[20 +: RW];
   assign rd_idx  = ir[7 +: RW];
   assign imm     = XLEN'($signed(imm32));

   // Decode: immediate format and legality, evaluated from the latched IR.
   always_comb begin
      imm32    = {{20{ir[31]}}, ir[31:20]};
      legal    = 1'b0;
      uses_rd  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         OP_REG: begin
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            {uses_rd, uses_rs1, uses_rs2} = 3'b111;
         end
         OP_IMM: begin
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
            {uses_rd, uses_rs1} = 2'b11;
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {ir[31:12], 12'b0};
            legal   = 1'b1;
            uses_rd = 1'b1;
         end
         OP_JAL: begin
            imm32   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            legal   = 1'b1;
            uses_rd = 1'b1;
         end
         OP_JALR: begin
            legal = (f3 == 3'b000);
            {uses_rd, uses_rs1} = 2'b11;
         end
         OP_BRANCH: begin
            imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
`ifdef MULTICYCLE_CORE_BRANCH_FULL_EN
            legal = (f3 != 3'b010) && (f3 != 3'b011);
`else
            legal = (f3 == 3'b000) || (f3 == 3'b001);
`endif
            {uses_rs1, uses_rs2} = 2'b11;
         end
         OP_LOAD: begin
            legal = (f3 == 3'b010);
            {uses_rd, uses_rs1} = 2'b11;
         end
         OP_STORE: begin
            imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            legal = (f3 == 3'b010);
            {uses_rs1, uses_rs2} = 2'b11;
         end
         default: legal = 1'b0;   // includes ECALL/EBREAK
      endcase
   end

   // Register indices beyond NREGS (RV32E-style builds) are illegal.
   assign dec_ok = legal
      && !(uses_rd  && ({1'b0, ir[11:7]}  >= 6'(NREGS)))
      && !(uses_rs1 && ({1'b0, ir[19:15]} >= 6'(NREGS)))
      && !(uses_rs2 && ({1'b0, ir[24:20]} >= 6'(NREGS)));

   logic [XLEN-1:0] op_b, alu_res, add_res, br_tgt, tgt, pc4, exec_res;
   logic [SHW-1:0]  shamt;
   logic            taken, exec_bad;

   assign pc4     = pc + XLEN'(4);
   assign op_b    = (opcode == OP_REG) ? rs2_q : imm;
   assign shamt   = op_b[SHW-1:0];
   assign add_res = rs1_q + imm;
   assign br_tgt  = pc + imm;
   assign tgt     = (opcode == OP_JALR) ? {add_res[XLEN-1:1], 1'b0} : br_tgt;

   always_comb begin
      alu_res = '0;
      case (f3)
         3'b000: alu_res = (opcode == OP_REG && ir[30]) ? rs1_q - op_b : rs1_q + op_b;
         3'b001: alu_res = rs1_q << shamt;
         3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_q) < $signed(op_b))};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, (rs1_q < op_b)};
         3'b100: alu_res = rs1_q ^ op_b;
         3'b101: alu_res = ir[30] ? $unsigned($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
         3'b110: alu_res = rs1_q | op_b;
         3'b111: alu_res = rs1_q & op_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000: taken = (rs1_q == rs2_q);
         3'b001: taken = (rs1_q != rs2_q);
`ifdef MULTICYCLE_CORE_BRANCH_FULL_EN
         3'b100: taken = ($signed(rs1_q) <  $signed(rs2_q));
         3'b101: taken = ($signed(rs1_q) >= $signed(rs2_q));
         3'b110: taken = (rs1_q <  rs2_q);
         3'b111: taken = (rs1_q >= rs2_q);
`endif
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      exec_res = alu_res;
      exec_bad = 1'b0;
      case (opcode)
         OP_LUI:             exec_res = imm;
         OP_AUIPC:           exec_res = br_tgt;
         OP_JAL, OP_JALR: begin
            exec_res = pc4;
            exec_bad = (tgt[1:0] != 2'b00);
         end
         OP_LOAD, OP_STORE: begin
            exec_res = add_res;
            exec_bad = (add_res[1:0] != 2'b00);
         end
         OP_BRANCH:          exec_bad = taken && (tgt[1:0] != 2'b00);
         default:            exec_res = alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      halt      = 1'b0;
      case (state)
         S_FETCH: begin
            if (run) begin
               mem_req  = 1'b1;
               mem_addr = pc;
               if (mem_ready) state_nx = S_DECODE;
            end
         end
         S_DECODE: state_nx = dec_ok ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (exec_bad)                                      state_nx = S_HALT;
            else if (opcode == OP_BRANCH) begin
               retire   = 1'b1;
               state_nx = S_FETCH;
            end
            else if (opcode == OP_LOAD || opcode == OP_STORE)  state_nx = S_MEM;
            else                                               state_nx = S_WB;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = res_q;
            if (opcode == OP_STORE) begin
               mem_we    = 1'b1;
               mem_wdata = rs2_q;
            end
            if (mem_ready) begin
               retire   = (opcode == OP_STORE);
               state_nx = (opcode == OP_STORE) ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            retire   = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALT:  halt = 1'b1;
         default: state_nx = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run   <= 1'b0;
         pc    <= RESET_PC;
         ir    <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         res_q <= '0;
         npc_q <= '0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            S_FETCH:  if (run && mem_ready) ir <= mem_rdata[31:0];
            S_DECODE: begin
               rs1_q <= rf[rs1_idx];
               rs2_q <= rf[rs2_idx];
            end
            S_EXEC: begin
               if (!exec_bad) begin
                  res_q <= exec_res;
                  npc_q <= (opcode == OP_JAL || opcode == OP_JALR) ? tgt : pc4;
                  if (opcode == OP_BRANCH) pc <= taken ? tgt : pc4;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (opcode == OP_STORE) pc    <= pc4;
                  else                    res_q <= mem_rdata;
               end
            end
            S_WB: begin
               // x0 is never written, so it stays at its reset value of zero.
               if (rd_idx != '0) rf[rd_idx] <= res_q;
               pc <= npc_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed self-checking bench for multicycle_core
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, mem_ready, retire, halt;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   multicycle_core dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire), .halt(halt)
   );

   always #5 clk = ~clk;

   localparam logic [6:0]  OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111, JALR = 7'b1100111;
   localparam logic [31:0] ECALL = 32'h00000073;

   int          n_checks = 0, n_errors = 0;
   int          cyc = 0, wait_n = 0;
   logic [31:0] mem [256];
   int          acc_cyc[$], rt_q[$];
   logic [31:0] acc_addr[$], wr_addr[$], wr_data[$];
   bit          acc_we[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, logic [6:0] op);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], op};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, OPI); endfunction
   function automatic logic [31:0] sw(int rs2, int rs1, int imm); return enc_s(imm, rs2, rs1, 2, 7'b0100011); endfunction
   function automatic logic [31:0] lw(int rd, int rs1, int imm); return enc_i(imm, rs1, 2, rd, 7'b0000011); endfunction

   task automatic put(input logic [31:0] a, input logic [31:0] w);
      mem[a[9:2]] = w;
   endtask

   // Memory responder with a programmable number of wait cycles per access, plus bus/retire logging.
   initial begin
      bit prev_req = 1'b0, prev_ready = 1'b0;
      int wcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever @(negedge clk) begin
         cyc++;
         if (mem_req) begin
            if (!prev_req || prev_ready) begin
               acc_cyc.push_back(cyc); acc_addr.push_back(mem_addr); acc_we.push_back(mem_we);
               wcnt = 0;
            end
            mem_ready = (wcnt == wait_n);
            mem_rdata = '0;
            if (mem_ready && mem_we) begin
               mem[mem_addr[9:2]] = mem_wdata;
               wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
            end else if (mem_ready) mem_rdata = mem[mem_addr[9:2]];
            if (!mem_ready) wcnt++;
         end else begin
            mem_ready = (wait_n == 0);
            mem_rdata = '0;
            wcnt = 0;
         end
         prev_req = mem_req; prev_ready = mem_ready;
         #1;
         if (retire) rt_q.push_back(cyc);
      end
   end

   function automatic int lat_of(logic [31:0] a);
      for (int i = 0; i < acc_addr.size(); i++)
         if (!acc_we[i] && acc_addr[i] == a)
            foreach (rt_q[j]) if (rt_q[j] >= acc_cyc[i]) return rt_q[j] - acc_cyc[i] + 1;
      return -1;
   endfunction

   function automatic int count_addr(logic [31:0] a);
      int n = 0;
      foreach (acc_addr[i]) if (acc_addr[i] == a) n++;
      return n;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic start(input int waits, input string tag);
      wait_n = waits;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      acc_cyc.delete(); acc_addr.delete(); acc_we.delete(); rt_q.delete(); wr_addr.delete(); wr_data.delete();
      check({tag, "_rst_req"}, {31'b0, mem_req}, 0);
      check({tag, "_rst_halt"}, {31'b0, halt}, 0);
      check({tag, "_rst_addr"}, mem_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check({tag, "_first_req"}, {31'b0, mem_req}, 1);
      check({tag, "_first_addr"}, mem_addr, 32'h0);
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halt && n < 2000) begin @(negedge clk); n++; end
      check({tag, "_halted"}, {31'b0, halt}, 1);
   endtask

   initial begin
      // Reset mid-transaction drops the request on the next cycle.
      clear_mem();
      start(3, "mid");
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_req_drop", {31'b0, mem_req}, 0);
      check("mid_rst_no_retire", {31'b0, retire}, 0);

      // ALU sequence, zero wait.
      clear_mem();
      put(0, addi(1, 0, 5)); put(4, addi(2, 0, -3)); put(8, enc_r(0, 2, 1, 0, 3));
      put(12, sw(3, 0, 64)); put(16, ECALL);
      start(0, "alu");
      run_to_halt("alu");
      check("alu_x3", mem[16], 32'd2);
      check("alu_retires", rt_q.size(), 4);
      if (rt_q.size() >= 3) begin
         check("alu_gap1", rt_q[1] - rt_q[0], 4);
         check("alu_gap2", rt_q[2] - rt_q[1], 4);
      end
      check("alu_lat", lat_of(0), 4);
      check("alu_sw_lat", lat_of(12), 4);
      check("alu_halt_pc", dut.pc, 16);

      // Store then load with two wait cycles per access.
      clear_mem();
      put(0, enc_j(32, 0)); put(32, addi(3, 0, 2)); put(36, sw(3, 0, 8)); put(40, lw(4, 0, 8));
      put(44, sw(4, 0, 68)); put(48, ECALL);
      start(2, "ldst");
      run_to_halt("ldst");
      check("ldst_addi_lat", lat_of(32), 6);
      check("ldst_sw_lat", lat_of(36), 8);
      check("ldst_lw_lat", lat_of(40), 9);
      check("ldst_wr_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hFFFF_FFFF, 8);
      check("ldst_wr_data", wr_data.size() > 0 ? wr_data[0] : 32'hFFFF_FFFF, 2);
      check("ldst_x4", mem[17], 32'd2);

      // Countdown loop with BNE, then a misaligned load halts.
      clear_mem();
      put(0, addi(1, 0, 3)); put(4, addi(7, 7, 1)); put(8, addi(1, 1, -1));
      put(12, enc_b(-8, 0, 1, 1)); put(16, sw(7, 0, 64)); put(20, lw(5, 0, 2));
      start(0, "loop");
      run_to_halt("loop");
      check("loop_count", mem[16], 32'd3);
      check("loop_br_lat", lat_of(12), 3);
      check("loop_retires", rt_q.size(), 11);
      check("loop_halt_pc", dut.pc, 20);
      check("loop_x5", dut.rf[5], 0);
      check("loop_no_access", count_addr(2), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("loop_halt_req", {29'b0, mem_req, retire, halt}, 32'b001);
      end

      // LUI/ADDI, JAL to 0xFFFFFFFC and PC wrap back to low memory.
      clear_mem();
      put(0, {20'hFFFFF, 5'd6, LUI}); put(4, addi(6, 6, 12'h7FF)); put(8, enc_j(-12, 0));
      put(32'hFFFF_FFFC, enc_j(16, 9)); put(12, sw(6, 0, 64)); put(16, sw(9, 0, 68)); put(20, ECALL);
      mem[17] = 32'hDEAD;
      start(0, "wrap");
      run_to_halt("wrap");
      check("wrap_x6", mem[16], 32'hFFFF_F7FF);
      check("wrap_link", mem[17], 32'h0);
      check("wrap_fetch_top", count_addr(32'hFFFF_FFFC), 1);
      check("wrap_halt_pc", dut.pc, 20);

      // Shifts, compares, SUB and JALR with bit 0 cleared.
      clear_mem();
      put(0, addi(1, 0, -16)); put(4, enc_i(12'h402, 1, 5, 2, OPI)); put(8, enc_r(0, 1, 0, 3, 3));
      put(12, enc_r(32, 1, 0, 0, 4)); put(16, enc_i(33, 0, 0, 5, JALR)); put(20, ECALL);
      put(32, sw(2, 0, 64)); put(36, sw(3, 0, 68)); put(40, sw(4, 0, 72)); put(44, sw(5, 0, 76)); put(48, ECALL);
      start(1, "ops");
      run_to_halt("ops");
      check("ops_srai", mem[16], 32'hFFFF_FFFC);
      check("ops_sltu", mem[17], 32'd1);
      check("ops_sub", mem[18], 32'd16);
      check("ops_jalr_link", mem[19], 32'd20);
      check("ops_halt_pc", dut.pc, 48);

      // BLT x2,x1,+8 with x2=-3, x1=5.
      clear_mem();
      put(0, addi(1, 0, 5)); put(4, addi(2, 0, -3)); put(8, enc_b(8, 1, 2, 4)); put(12, ECALL);
      put(16, addi(10, 0, 1)); put(20, sw(10, 0, 64)); put(24, ECALL);
      start(0, "blt");
      run_to_halt("blt");
`ifdef MULTICYCLE_CORE_BRANCH_FULL_EN
      check("blt_taken", mem[16], 32'd1);
      check("blt_halt_pc", dut.pc, 24);
      check("blt_lat", lat_of(8), 3);
`else
      check("blt_illegal_mem", mem[16], 32'd0);
      check("blt_halt_pc", dut.pc, 8);
      check("blt_retires", rt_q.size(), 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
